main_mem_arb: RTL and testbench

MAIN_MEM_ARB -- requirements
Module: main_mem_arb

---
 rtl/main_mem_arb.sv | 177 +++++++++++++++++
 tb/tb_main_mem_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arb.sv
// main_mem_arb
// Arbitrates one memory port between an instruction-fetch requester and a
// data memory-access requester. Grants are combinational in the request
// cycle. A starvation counter flips priority to fetch after STARVE_MAX
// consecutive denied fetch cycles. Reads and illegal requests return one
// cycle later through a single-stage return register. Legal stores return
// nothing.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   if_req/if_addr/if_gnt         fetch request, byte address, grant
//   if_rsp_vld/_dat/_err          fetch response
//   ma_req/_wen/_addr/_wdat/_be   memory-access request (load/store)
//   ma_gnt                        memory-access grant
//   ma_rsp_vld/_dat/_err          load response, or error for any rejected access
//   mem_cs/_wen/_addr/_dat_in     memory control and write data
//   mem_dat_out                   memory read data, one cycle after a read
//   fetch_pri                     1 while the arbiter favours fetch
module main_mem_arb #(
  parameter int MAIN_MEM_BYTE_ADD_W = 8,
  parameter int STARVE_MAX          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rsp_vld,
  output logic [31:0] if_rsp_dat,
  output logic        if_rsp_err,
  input  logic        ma_req,
  input  logic        ma_wen,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdat,
  input  logic [3:0]  ma_be,
  output logic        ma_gnt,
  output logic        ma_rsp_vld,
  output logic [31:0] ma_rsp_dat,
  output logic        ma_rsp_err,
  output logic        mem_cs,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dat_in,
  input  logic [31:0] mem_dat_out,
  output logic        fetch_pri
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {
    DATA_PRI  = 1'b0,
    FETCH_PRI = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_cnt_next;

  // Return register: who owns the pending response, whether it is an error,
  // and which bytes of the read word are kept.
  logic             r_rsp_vld;
  logic             r_rsp_fetch;
  logic             r_rsp_err;
  logic [3:0]       r_rsp_be;

  logic             w_if_legal;
  logic             w_ma_legal;
  logic [31:0]      w_ma_mask;
  logic [31:0]      w_rsp_mask;
  logic             w_rsp_live;
  logic [31:0]      w_rsp_dat;

  // Word aligned and inside the implemented address space.
  assign w_if_legal = (if_addr[1:0] == 2'b00) &&
                      (if_addr[31:MAIN_MEM_BYTE_ADD_W] == '0);
  assign w_ma_legal = (ma_addr[1:0] == 2'b00) &&
                      (ma_addr[31:MAIN_MEM_BYTE_ADD_W] == '0);

  // Expand byte enables into 8-bit lane masks.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_ma_mask[8*gi +: 8]  = {8{ma_be[gi]}};
      assign w_rsp_mask[8*gi +: 8] = {8{r_rsp_be[gi]}};
    end
  endgenerate

  // Grants: a conflict goes to whichever side the FSM favours; a lone
  // requester always wins. Nothing is granted while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    ma_gnt = 1'b0;
    if (rst_n) begin
      if (if_req && ma_req) begin
        if (r_state == FETCH_PRI) if_gnt = 1'b1;
        else                      ma_gnt = 1'b1;
      end else begin
        if_gnt = if_req;
        ma_gnt = ma_req;
      end
    end
  end

  // Memory port: only legal granted requests reach the memory.
  always_comb begin
    mem_cs     = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (if_gnt && w_if_legal) begin
      mem_cs   = 1'b1;
      mem_addr = if_addr;
    end else if (ma_gnt && w_ma_legal) begin
      mem_cs   = 1'b1;
      mem_wen  = ma_wen;
      mem_addr = ma_addr;
      if (ma_wen) mem_dat_in = ma_wdat & w_ma_mask;
    end
  end

  // Starvation counter: counts denied fetch cycles, saturating.
  always_comb begin
    w_starve_cnt_next = r_starve_cnt;
    if (if_gnt) begin
      w_starve_cnt_next = '0;
    end else if (if_req && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
      w_starve_cnt_next = r_starve_cnt + 1'b1;
    end
  end

  // Priority flips as the counter reaches its limit, so the very next cycle
  // after the STARVE_MAX-th denial already favours fetch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DATA_PRI:  if (w_starve_cnt_next == CNT_W'(STARVE_MAX)) w_state_next = FETCH_PRI;
      FETCH_PRI: if (if_gnt) w_state_next = DATA_PRI;
      default:   w_state_next = DATA_PRI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= DATA_PRI;
      r_starve_cnt <= '0;
      r_rsp_vld    <= 1'b0;
      r_rsp_fetch  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_be     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_cnt_next;
      // Every fetch answers; a memory access answers unless it is a legal store.
      r_rsp_vld    <= if_gnt || (ma_gnt && (!ma_wen || !w_ma_legal));
      r_rsp_fetch  <= if_gnt;
      r_rsp_err    <= if_gnt ? !w_if_legal : !w_ma_legal;
      r_rsp_be     <= if_gnt ? 4'hF : ma_be;
    end
  end

  // A pending response is suppressed while reset is held so an in-flight
  // read never surfaces during reset.
  assign w_rsp_live = r_rsp_vld && rst_n;
  assign w_rsp_dat  = r_rsp_err ? 32'h0 : (mem_dat_out & w_rsp_mask);

  assign if_rsp_vld = w_rsp_live && r_rsp_fetch;
  assign if_rsp_err = if_rsp_vld && r_rsp_err;
  assign if_rsp_dat = if_rsp_vld ? w_rsp_dat : 32'h0;

  assign ma_rsp_vld = w_rsp_live && !r_rsp_fetch;
  assign ma_rsp_err = ma_rsp_vld && r_rsp_err;
  assign ma_rsp_dat = ma_rsp_vld ? w_rsp_dat : 32'h0;

  assign fetch_pri  = (r_state == FETCH_PRI);

endmodule

// File: tb/tb_main_mem_arb.sv
module tb_main_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rsp_vld;
  logic [31:0] if_rsp_dat;
  logic        if_rsp_err;
  logic        ma_req;
  logic        ma_wen;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdat;
  logic [3:0]  ma_be;
  logic        ma_gnt;
  logic        ma_rsp_vld;
  logic [31:0] ma_rsp_dat;
  logic        ma_rsp_err;
  logic        mem_cs;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dat_in;
  logic [31:0] mem_dat_out;
  logic        fetch_pri;

  int checks = 0;
  int errors = 0;

  // Scoreboard: one expected response word pushed per cycle, popped next cycle.
  logic [67:0] exp_q[$];
  logic [67:0] exp_rsp;

  wire [67:0] rsp_obs = {if_rsp_vld, if_rsp_err, if_rsp_dat, ma_rsp_vld, ma_rsp_err, ma_rsp_dat};
  wire [65:0] mem_obs = {mem_cs, mem_wen, mem_addr, mem_dat_in};
  wire [1:0]  gnt_obs = {if_gnt, ma_gnt};

  main_mem_arb #(.MAIN_MEM_BYTE_ADD_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rsp_vld(if_rsp_vld), .if_rsp_dat(if_rsp_dat), .if_rsp_err(if_rsp_err),
    .ma_req(ma_req), .ma_wen(ma_wen), .ma_addr(ma_addr), .ma_wdat(ma_wdat), .ma_be(ma_be),
    .ma_gnt(ma_gnt), .ma_rsp_vld(ma_rsp_vld), .ma_rsp_dat(ma_rsp_dat), .ma_rsp_err(ma_rsp_err),
    .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out), .fetch_pri(fetch_pri)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [67:0] f_rsp(input logic err, input logic [31:0] dat);
    return {1'b1, err, dat, 34'h0};
  endfunction

  function automatic logic [67:0] m_rsp(input logic err, input logic [31:0] dat);
    return {34'h0, 1'b1, err, dat};
  endfunction

  // Memory model: read data valid one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_cs && !mem_wen) mem_dat_out <= mem_word(mem_addr);
    else                    mem_dat_out <= 32'hBAD0BAD0;
  end

  // Apply one cycle of stimulus, then wait for the falling edge to sample.
  task automatic drive(input logic rn, input logic ir, input logic [31:0] ia,
                       input logic mr, input logic mw, input logic [31:0] ma,
                       input logic [31:0] wd, input logic [3:0] be);
    @(posedge clk);
    #1;
    rst_n = rn; if_req = ir; if_addr = ia;
    ma_req = mr; ma_wen = mw; ma_addr = ma; ma_wdat = wd; ma_be = be;
    @(negedge clk);
    $display("txn t=%0t rst_n=%b if_req=%b if_addr=%h ma_req=%b ma_wen=%b ma_addr=%h gnt=%b mem_cs=%b fetch_pri=%b",
             $time, rn, ir, ia, mr, mw, ma, gnt_obs, mem_cs, fetch_pri);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL reset_rsp: got %h want %h", rsp_obs, exp_rsp); end
      checks++;
      if ({gnt_obs, mem_obs} !== 68'h0) begin errors++; $display("FAIL reset_outputs: got gnt=%b mem=%h want all 0", gnt_obs, mem_obs); end
      checks++;
      if (fetch_pri !== 1'b0) begin errors++; $display("FAIL reset_pri: got %b want 0", fetch_pri); end
      exp_q.push_back('0);
    end
  endtask

  task automatic test_fetch();
    // First cycle out of reset: lone fetch granted immediately.
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_rsp = '0;
    if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
    checks++;
    if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL fetch_rsp0: got %h want %h", rsp_obs, exp_rsp); end
    checks++;
    if (gnt_obs !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", gnt_obs); end
    checks++;
    if (mem_obs !== {1'b1, 1'b0, 32'h10, 32'h0}) begin errors++; $display("FAIL fetch_mem: got %h want cs=1 wen=0 addr=10", mem_obs); end
    exp_q.push_back(f_rsp(1'b0, 32'hDEADBEEF));
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_rsp = '0;
    if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
    checks++;
    if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL fetch_rsp: got %h want %h", rsp_obs, exp_rsp); end
    checks++;
    if ({gnt_obs, mem_obs} !== 68'h0) begin errors++; $display("FAIL idle_outputs: got gnt=%b mem=%h want all 0", gnt_obs, mem_obs); end
    exp_q.push_back('0);
  endtask

  task automatic test_store();
    logic [31:0] addrs[3] = '{32'h20, 32'h24, 32'h28};
    logic [3:0]  bes[3]   = '{4'b0011, 4'b0001, 4'b1111};
    logic [31:0] wds[3]   = '{32'h12345678, 32'hCAFEF00D, 32'hA5A5A5A5};
    logic [31:0] dins[3]  = '{32'h00005678, 32'h0000000D, 32'hA5A5A5A5};
    for (int r = 0; r < 4; r++) begin
      if (r < 3) drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, addrs[r], wds[r], bes[r]);
      else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL store_rsp%0d: got %h want %h", r, rsp_obs, exp_rsp); end
      if (r < 3) begin
        checks++;
        if (gnt_obs !== 2'b01) begin errors++; $display("FAIL store_gnt%0d: got %b want 01", r, gnt_obs); end
        checks++;
        if (mem_obs !== {1'b1, 1'b1, addrs[r], dins[r]}) begin errors++; $display("FAIL store_mem%0d: got %h want %h", r, mem_obs, {1'b1, 1'b1, addrs[r], dins[r]}); end
      end
      exp_q.push_back('0);
    end
  endtask

  task automatic test_illegal();
    logic        isf[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        wen[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] addrs[4] = '{32'h102, 32'h11, 32'h200, 32'hFE};
    for (int r = 0; r < 5; r++) begin
      if (r < 4) drive(1'b1, isf[r], addrs[r], !isf[r], wen[r], addrs[r], 32'hFFFFFFFF, 4'hF);
      else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL illegal_rsp%0d: got %h want %h", r, rsp_obs, exp_rsp); end
      if (r < 4) begin
        checks++;
        if (gnt_obs !== {isf[r], !isf[r]}) begin errors++; $display("FAIL illegal_gnt%0d: got %b want %b", r, gnt_obs, {isf[r], !isf[r]}); end
        checks++;
        if ({mem_cs, mem_wen} !== 2'b00) begin errors++; $display("FAIL illegal_mem%0d: got cs=%b wen=%b want 0 0", r, mem_cs, mem_wen); end
        exp_q.push_back(isf[r] ? f_rsp(1'b1, 32'h0) : m_rsp(1'b1, 32'h0));
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        isf[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] addrs[4] = '{32'h04, 32'h08, 32'h0C, 32'h40};
    logic [3:0]  bes[4]   = '{4'b1111, 4'b1111, 4'b0001, 4'b0011};
    for (int r = 0; r < 5; r++) begin
      if (r < 4) drive(1'b1, isf[r], addrs[r], !isf[r], 1'b0, addrs[r], 32'h0, bes[r]);
      else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL b2b_rsp%0d: got %h want %h", r, rsp_obs, exp_rsp); end
      if (r < 4) begin
        checks++;
        if (gnt_obs !== {isf[r], !isf[r]}) begin errors++; $display("FAIL b2b_gnt%0d: got %b want %b", r, gnt_obs, {isf[r], !isf[r]}); end
        checks++;
        if (mem_obs[65:32] !== {1'b1, 1'b0, addrs[r]}) begin errors++; $display("FAIL b2b_mem%0d: got %h want cs=1 wen=0 addr=%h", r, mem_obs[65:32], addrs[r]); end
        exp_q.push_back(isf[r] ? f_rsp(1'b0, mem_word(addrs[r])) : m_rsp(1'b0, mem_word(addrs[r]) & be_mask(bes[r])));
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic test_starve();
    logic fi;
    // Both held: four data grants, then one fetch grant, repeating.
    for (int c = 0; c < 11; c++) begin
      if (c < 10) drive(1'b1, 1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 32'h0, 4'hF);
      else        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      fi = ((c % 5) == 4);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL starve_rsp%0d: got %h want %h", c, rsp_obs, exp_rsp); end
      checks++;
      if (fetch_pri !== fi) begin errors++; $display("FAIL starve_pri%0d: got %b want %b", c, fetch_pri, fi); end
      if (c < 10) begin
        checks++;
        if (gnt_obs !== {fi, !fi}) begin errors++; $display("FAIL starve_gnt%0d: got %b want %b", c, gnt_obs, {fi, !fi}); end
        checks++;
        if (mem_addr !== (fi ? 32'h30 : 32'h34)) begin errors++; $display("FAIL starve_addr%0d: got %h want %h", c, mem_addr, fi ? 32'h30 : 32'h34); end
        exp_q.push_back(fi ? f_rsp(1'b0, mem_word(32'h30)) : m_rsp(1'b0, mem_word(32'h34)));
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_rsp = '0;
    if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
    checks++;
    if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL rmid_rsp0: got %h want %h", rsp_obs, exp_rsp); end
    checks++;
    if (gnt_obs !== 2'b10) begin errors++; $display("FAIL rmid_gnt: got %b want 10", gnt_obs); end
    exp_q.push_back('0);  // reset arrives next cycle, so this read never answers
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, 4'hF);
      else       drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      exp_rsp = '0;
      if (exp_q.size() > 0) exp_rsp = exp_q.pop_front();
      checks++;
      if (rsp_obs !== exp_rsp) begin errors++; $display("FAIL rmid_rsp%0d: got %h want %h", c + 1, rsp_obs, exp_rsp); end
      checks++;
      if ({gnt_obs, mem_obs, fetch_pri} !== 69'h0) begin errors++; $display("FAIL rmid_out%0d: got gnt=%b mem=%h pri=%b want all 0", c + 1, gnt_obs, mem_obs, fetch_pri); end
      exp_q.push_back('0);
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    ma_req = 1'b0; ma_wen = 1'b0; ma_addr = '0; ma_wdat = '0; ma_be = '0;
    test_reset();
    test_fetch();
    test_store();
    test_illegal();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
